// File: rtl/lfu_counter_bank_if.sv
// Hit/fill event inputs and counter outputs of one LFU counter bank.
// The master side produces hit and fill events. The slave side is the counter bank.
interface lfu_counter_bank_if #(
  parameter int WIDTH = 4
);
  logic             hit_valid;
  logic [1:0]       hit_way;
  logic             fill_valid;
  logic [3:0]       fill_sel;
  logic [WIDTH-1:0] count0;
  logic [WIDTH-1:0] count1;
  logic [WIDTH-1:0] count2;
  logic [WIDTH-1:0] count3;
  logic             age_event;
  logic             fill_err;

  modport master (
    output hit_valid, hit_way, fill_valid, fill_sel,
    input  count0, count1, count2, count3, age_event, fill_err
  );

  modport slave (
    input  hit_valid, hit_way, fill_valid, fill_sel,
    output count0, count1, count2, count3, age_event, fill_err
  );
endinterface

// File: rtl/lfu_counter_bank.sv
// Per-set bank of four saturating use-frequency counters for 4-way LFU replacement.
// Hits increment the way's counter and fills restart it at 1.
// All counters are halved when a hit finds a saturated counter, or after every
// AGE_PERIOD hits, so that old popularity decays.
module lfu_counter_bank #(
  parameter int WIDTH      = 4,
  parameter int AGE_PERIOD = 16
) (
  input logic               i_clk,
  input logic               i_reset,
  lfu_counter_bank_if.slave bus
);

  localparam int              ACC_W    = (AGE_PERIOD < 1) ? 1 : $clog2(AGE_PERIOD + 1);
  localparam logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}};
  localparam logic [ACC_W-1:0] ACC_LAST = (AGE_PERIOD == 0) ? '0 : ACC_W'(AGE_PERIOD - 1);

  logic [WIDTH-1:0] r_count [4];
  logic [ACC_W-1:0] r_acc;
  logic             r_age_event;
  logic             r_fill_err;

  logic             w_fill_ok;
  logic [1:0]       w_fill_way;
  logic             w_hit_sat;
  logic             w_period;
  logic             w_aging;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_base     [4];
  logic [WIDTH-1:0] w_count_nxt [4];

  function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] v);
    return v >> 1;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Encoding is only meaningful when the input is known to be one-hot.
  function automatic logic [1:0] enc_onehot4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (v[k]) idx = 2'(k);
    end
    return idx;
  endfunction

  // Decode events, decide on aging, and form the next counter values.
  // A hit on a saturated counter always coincides with aging, so base+1 cannot wrap.
  always_comb begin
    w_fill_ok  = bus.fill_valid && is_onehot4(bus.fill_sel);
    w_fill_way = enc_onehot4(bus.fill_sel);
    w_hit_sat  = bus.hit_valid && (r_count[bus.hit_way] == MAX);
    w_period   = (AGE_PERIOD != 0) && bus.hit_valid && (r_acc == ACC_LAST);
    w_aging    = w_hit_sat || w_period;

    w_acc_nxt = r_acc;
    if (w_aging)            w_acc_nxt = '0;
    else if (bus.hit_valid) w_acc_nxt = r_acc + 1'b1;

    for (int i = 0; i < 4; i++) begin
      w_base[i]      = w_aging ? halve(r_count[i]) : r_count[i];
      w_count_nxt[i] = w_base[i];
      if (w_fill_ok && (w_fill_way == 2'(i)))
        w_count_nxt[i] = {{(WIDTH-1){1'b0}}, 1'b1};
      else if (bus.hit_valid && (bus.hit_way == 2'(i)))
        w_count_nxt[i] = w_base[i] + 1'b1;
    end
  end

  // Register counters, hit accumulator and the one-cycle status pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) r_count[i] <= '0;
      r_acc       <= '0;
      r_age_event <= 1'b0;
      r_fill_err  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) r_count[i] <= w_count_nxt[i];
      r_acc       <= w_acc_nxt;
      r_age_event <= w_aging;
      r_fill_err  <= bus.fill_valid && !w_fill_ok;
    end
  end

  assign bus.count0    = r_count[0];
  assign bus.count1    = r_count[1];
  assign bus.count2    = r_count[2];
  assign bus.count3    = r_count[3];
  assign bus.age_event = r_age_event;
  assign bus.fill_err  = r_fill_err;

endmodule

// File: tb/tb_lfu_counter_bank.sv
// Bench for lfu_counter_bank: one instance with periodic aging (AGE_PERIOD=16) and
// one with saturation-only aging (AGE_PERIOD=0), both fed the same directed stimulus.
// A behavioural model is checked against both every cycle.
// Literal expectations pin the model to hand-computed values.
module tb_lfu_counter_bank;

  logic clk;
  logic reset;

  lfu_counter_bank_if #(.WIDTH(4)) if16 ();
  lfu_counter_bank_if #(.WIDTH(4)) if0  ();

  lfu_counter_bank #(.WIDTH(4), .AGE_PERIOD(16)) dut16 (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (if16.slave)
  );

  lfu_counter_bank #(.WIDTH(4), .AGE_PERIOD(0)) dut0 (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // Model state: index 0 -> AGE_PERIOD=16 instance, index 1 -> AGE_PERIOD=0 instance.
  int m_cnt [2][4];
  int m_acc [2];
  int m_age [2];
  int m_err [2];
  int m_period [2];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  function automatic int dut_count(input int k, input int i);
    logic [3:0] v;
    if (k == 0) begin
      case (i)
        0: v = if16.count0;
        1: v = if16.count1;
        2: v = if16.count2;
        default: v = if16.count3;
      endcase
    end else begin
      case (i)
        0: v = if0.count0;
        1: v = if0.count1;
        2: v = if0.count2;
        default: v = if0.count3;
      endcase
    end
    return int'(v);
  endfunction

  // Model step, written from the counting rules directly.
  task automatic model_step(input bit rst, input bit hv, input int hw, input bit fv,
                            input logic [3:0] fs);
    int  ones;
    int  fway;
    bit  fill_ok;
    bit  aging;
    int  nxt [4];
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
        m_acc[k] = 0;
        m_age[k] = 0;
        m_err[k] = 0;
      end else begin
        ones = 0;
        fway = 0;
        for (int i = 0; i < 4; i++) if (fs[i]) begin ones++; fway = i; end
        fill_ok = fv && (ones == 1);
        aging = hv && ((m_cnt[k][hw] == 15) ||
                       (m_period[k] != 0 && m_acc[k] == m_period[k] - 1));
        for (int i = 0; i < 4; i++) nxt[i] = aging ? m_cnt[k][i] / 2 : m_cnt[k][i];
        if (hv && !(fill_ok && fway == hw)) nxt[hw] = nxt[hw] + 1;
        if (fill_ok) nxt[fway] = 1;
        for (int i = 0; i < 4; i++) m_cnt[k][i] = nxt[i];
        if (aging)   m_acc[k] = 0;
        else if (hv) m_acc[k] = m_acc[k] + 1;
        m_age[k] = aging ? 1 : 0;
        m_err[k] = (fv && !fill_ok) ? 1 : 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("inst%0d_count%0d", k, i), dut_count(k, i), m_cnt[k][i]);
      check($sformatf("inst%0d_age_event", k),
            int'(k == 0 ? if16.age_event : if0.age_event), m_age[k]);
      check($sformatf("inst%0d_fill_err", k),
            int'(k == 0 ? if16.fill_err : if0.fill_err), m_err[k]);
    end
  endtask

  // One clock of stimulus: apply inputs, step model at the edge, compare 1ns later.
  task automatic cycle(input bit rst, input bit hv, input logic [1:0] hw, input bit fv,
                       input logic [3:0] fs);
    reset          = rst;
    if16.hit_valid = hv;  if0.hit_valid = hv;
    if16.hit_way   = hw;  if0.hit_way   = hw;
    if16.fill_valid = fv; if0.fill_valid = fv;
    if16.fill_sel  = fs;  if0.fill_sel  = fs;
    @(posedge clk);
    model_step(rst, hv, int'(hw), fv, fs);
    #1;
    compare_all();
  endtask

  task automatic do_hit(input logic [1:0] w);  cycle(1'b0, 1'b1, w, 1'b0, 4'b0000); endtask
  task automatic do_fill(input logic [1:0] w); cycle(1'b0, 1'b0, 2'd0, 1'b1, 4'b0001 << w); endtask
  task automatic do_idle();                    cycle(1'b0, 1'b0, 2'd3, 1'b0, 4'b1011); endtask
  task automatic do_reset();                   cycle(1'b1, 1'b1, 2'd1, 1'b1, 4'b0010); endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    m_period[0] = 16;
    m_period[1] = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
      m_acc[k] = 0; m_age[k] = 0; m_err[k] = 0;
    end
    reset = 1'b1;
    if16.hit_valid = 1'b0; if0.hit_valid = 1'b0;
    if16.hit_way = 2'd0;   if0.hit_way = 2'd0;
    if16.fill_valid = 1'b0; if0.fill_valid = 1'b0;
    if16.fill_sel = 4'd0;  if0.fill_sel = 4'd0;
    @(negedge clk);

    // Reset held two cycles with hits and fills driven.
    do_reset();
    do_reset();
    check("rst_count0", int'(if16.count0), 0);
    check("rst_count1", int'(if16.count1), 0);
    check("rst_age", int'(if16.age_event), 0);
    check("rst_err", int'(if16.fill_err), 0);

    // Basic counting on way 2.
    do_fill(2'd2);
    check("basic_c2_fill", int'(if16.count2), 1);
    do_hit(2'd2);
    check("basic_c2_h1", int'(if16.count2), 2);
    do_hit(2'd2);
    check("basic_c2_h2", int'(if16.count2), 3);
    do_hit(2'd2);
    check("basic_c2_h3", int'(if16.count2), 4);
    check("basic_c0", int'(if16.count0), 0);
    check("basic_c3", int'(if16.count3), 0);
    check("basic_age", int'(if16.age_event), 0);
    do_idle();

    // Saturation aging on the AGE_PERIOD=0 instance.
    do_reset();
    do_fill(2'd0);
    repeat (14) do_hit(2'd0);
    do_fill(2'd1);
    repeat (5) do_hit(2'd1);
    check("sat_setup_c0", int'(if0.count0), 15);
    check("sat_setup_c1", int'(if0.count1), 6);
    do_hit(2'd0);
    check("sat_c0", int'(if0.count0), 8);
    check("sat_c1", int'(if0.count1), 3);
    check("sat_c2", int'(if0.count2), 0);
    check("sat_c3", int'(if0.count3), 0);
    check("sat_age", int'(if0.age_event), 1);
    do_idle();
    check("sat_age_drop", int'(if0.age_event), 0);

    // Collision: fill and hit on the same way.
    do_reset();
    do_fill(2'd0);
    do_hit(2'd0);
    do_fill(2'd1);
    repeat (4) do_hit(2'd1);
    check("col_setup_c1", int'(if16.count1), 5);
    cycle(1'b0, 1'b1, 2'd1, 1'b1, 4'b0010);
    check("col_c1", int'(if16.count1), 1);
    check("col_c0", int'(if16.count0), 2);

    // Periodic aging on the AGE_PERIOD=16 instance.
    do_reset();
    do_fill(2'd0);
    repeat (7) do_hit(2'd0);
    do_fill(2'd1);
    repeat (8) do_hit(2'd1);
    check("per_setup_c0", int'(if16.count0), 8);
    check("per_setup_c1", int'(if16.count1), 9);
    check("per_setup_age", int'(if16.age_event), 0);
    do_hit(2'd2);
    check("per_c0", int'(if16.count0), 4);
    check("per_c1", int'(if16.count1), 4);
    check("per_c2", int'(if16.count2), 1);
    check("per_age", int'(if16.age_event), 1);
    repeat (7) do_hit(2'd2);
    repeat (8) do_hit(2'd3);
    check("per31_age", int'(if16.age_event), 0);
    do_hit(2'd0);
    check("per32_c0", int'(if16.count0), 3);
    check("per32_c1", int'(if16.count1), 2);
    check("per32_c2", int'(if16.count2), 4);
    check("per32_c3", int'(if16.count3), 4);
    check("per32_age", int'(if16.age_event), 1);

    // Bad fills with counts 2,3,4,5.
    do_reset();
    for (int w = 0; w < 4; w++) begin
      do_fill(2'(w));
      repeat (w + 1) do_hit(2'(w));
    end
    cycle(1'b0, 1'b0, 2'd0, 1'b1, 4'b0110);
    check("bad1_err", int'(if16.fill_err), 1);
    check("bad1_c1", int'(if16.count1), 3);
    check("bad1_c2", int'(if16.count2), 4);
    cycle(1'b0, 1'b0, 2'd0, 1'b1, 4'b0000);
    check("bad2_err", int'(if16.fill_err), 1);
    check("bad2_c0", int'(if16.count0), 2);
    check("bad2_c3", int'(if16.count3), 5);
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 4'b0110);
    check("nofill_err", int'(if16.fill_err), 0);
    // Bad fill concurrent with a hit still counts the hit.
    cycle(1'b0, 1'b1, 2'd3, 1'b1, 4'b1111);
    check("badhit_c3", int'(if16.count3), 6);
    check("badhit_err", int'(if16.fill_err), 1);

    // Reset mid-operation.
    do_reset();
    check("midrst_c3", int'(if16.count3), 0);
    do_hit(2'd3);
    check("postrst_c3", int'(if16.count3), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lfu_counter_bank.md
# lfu_counter_bank

Per-set bank of four saturating use-frequency counters for the 4-way LFU replacement path. It is the producer side of the LFU comparator. It maintains `count0..count3` from cache hit and fill events, and it consumes the comparator's one-hot victim select as its fill way. Counters age by halving so that old popularity decays.

## Interface
- `WIDTH`, 4: counter width; MAX = 2^WIDTH-1.
- `AGE_PERIOD`, 16: number of hit events between periodic halvings; 0 disables periodic aging.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: reset is synchronous and active-high; it dominates all other inputs.
- `hit_valid` in 1: a cache hit occurred this cycle.
- `hit_way` in 2: binary way index of the hit.
- `fill_valid` in 1: a line is being filled this cycle.
- `fill_sel` in 4: one-hot fill way, wired from the comparator's `cache_sel`.
- `count0`..`count3` out WIDTH each: registered counter values, fed to the comparator.
- `age_event` out 1: registered one-cycle pulse; high in the cycle in which the counts show a halving.
- `fill_err` out 1: registered one-cycle pulse; high when `fill_valid` was sampled with a non-one-hot `fill_sel`.

## Operation
- Reset state: all counts 0, `age_event` 0, `fill_err` 0, internal hit counter `acc` 0.
- Internal hit counter `acc`:
  - Width is $clog2(AGE_PERIOD+1), minimum 1.
  - Increments on each `hit_valid`.
- The aging condition for a cycle is true when either of these holds:
  - Saturating hit: `hit_valid` and the count of `hit_way` equals MAX.
  - Period reached: `AGE_PERIOD`≠0, `hit_valid`, and `acc` == AGE_PERIOD-1.
- When aging occurs, `acc` is cleared to 0; otherwise `acc` follows the normal increment rule.
- Per-cycle update, evaluated in this order:
  1. base_i = aging ? count_i>>1 : count_i.
  2. Valid fill on way f (`fill_valid` and `fill_sel` exactly one-hot): count_f <= 1.
  3. Hit on way h with h≠f (or no valid fill): count_h <= base_h+1. This cannot overflow, because a saturated counter has already been halved.
  4. All other ways: count_i <= base_i.
- Fill and hit on the same way in the same cycle: the fill wins and the count becomes 1. Aging still applies to the other ways, and the hit still counts toward `acc`.
- Fill and hit on different ways: both updates are applied.
- Invalid fill (`fill_valid` with `fill_sel` equal to 0000 or having ≥2 bits set):
  - The fill is ignored and `fill_err` pulses.
  - A concurrent hit and any aging are still processed normally.
- `fill_sel` is ignored while `fill_valid`=0.
- `hit_way` is ignored while `hit_valid`=0.
- Counters never wrap. Values are always within 0..MAX.

## Timing
- Latency is 1 cycle: inputs sampled at edge N are reflected in `count*`, `age_event` and `fill_err` after edge N.
- There is no backpressure. One hit and one fill are accepted every cycle.
- `age_event` and `fill_err` are high for exactly one cycle per triggering cycle. Back-to-back triggers produce back-to-back pulses.
- A reset asserted mid-operation clears everything at the next edge, regardless of the other inputs in that cycle. The first update after reset deasserts uses counts of 0.
- The outputs are registers, so the comparator sees stable counts for the whole cycle.

## Test plan
- Reset: hold `reset` for 2 cycles with hits and fills driven. Required: all counts 0, `age_event`=0, `fill_err`=0.
- Basic counting (WIDTH=4, AGE_PERIOD=16): fill `fill_sel`=0100, then 3 hits with `hit_way`=2. Required: count2 = 1,2,3,4 on successive cycles; other counts 0; no pulses.
- Saturation aging (AGE_PERIOD=0):
  - Setup: fill way0 plus 14 hits gives count0=15; fill way1 plus 5 hits gives count1=6.
  - Stimulus: one more hit on way0.
  - Required: count0=8, count1=3, count2=0, count3=0, `age_event`=1 for one cycle.
- Collision: count1=5, then in one cycle drive `hit_valid`, `hit_way`=1, `fill_valid`, `fill_sel`=0010. Required: count1=1 and the other counts unchanged.
- Periodic aging (AGE_PERIOD=16):
  - Setup: fill way0 then 7 hits on way0 (count0=8); fill way1 then 8 hits on way1 (count1=9). This is 15 hits total.
  - Stimulus: a 16th hit, on way2.
  - Required: count0=4, count1=4, count2=1, `age_event`=1; `acc` restarts so that the 32nd hit ages again.
- Bad fill: with counts 2,3,4,5, drive `fill_valid` with `fill_sel`=0110, then with `fill_sel`=0000. Required: counts unchanged; `fill_err`=1 in each following cycle.
